// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake-body sequencer: the 2-bit direction
// encoding stored in every ring slot and the sequencer state enum.
// -----------------------------------------------------------------------------
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } snake_state_t;

endpackage

// File: rtl/snake_ring_phase.sv
// -----------------------------------------------------------------------------
// snake_ring_phase
// Mod-DEPTH phase counter tracking which segment index currently sits on the
// output of the shift ring.
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (idx -> 0)
//   load0  in   force idx to 0 next cycle
//   load1  in   force idx to 1 next cycle (ring content moved one segment deeper)
//   idx    out  current phase, 0..DEPTH-1
//   wrap   out  idx == DEPTH-1
// -----------------------------------------------------------------------------
module snake_ring_phase #(
  parameter int DEPTH = 234,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load0,
  input  logic             load1,
  output logic [IDX_W-1:0] idx,
  output logic             wrap
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  assign wrap = (idx_q == IDX_W'(DEPTH - 1));
  assign idx  = idx_q;

  always_comb begin
    idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    if (load0) begin
      idx_d = '0;
    end else if (load1) begin
      idx_d = IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// -----------------------------------------------------------------------------
// snake_body_ctrl
// Sequencer for an external free-running shift ring holding the snake body as
// one direction per segment. Closes the ring (sr_in <- sr_out), fills it with
// INIT_DIR after reset/restart, inserts a new head once per revolution, tracks
// the snake length and streams every stored segment once per revolution.
//   clk, rst           clock, synchronous active-high reset
//   restart            re-clear the ring (ignored while already clearing)
//   move_valid/dir/grow, move_ready   new-head handshake
//   sr_in / sr_out     ring input / ring last stage
//   seg_valid/idx/dir/tail, frame_start   registered segment stream
//   length, full       registered snake length and length==DEPTH
// -----------------------------------------------------------------------------
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int               DEPTH    = 234,
  parameter int               WIDTH    = 2,
  parameter int               INIT_LEN = 3,
  parameter logic [WIDTH-1:0] INIT_DIR = WIDTH'(DIR_RIGHT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       restart,
  input  logic                       move_valid,
  input  logic [WIDTH-1:0]           move_dir,
  input  logic                       move_grow,
  output logic                       move_ready,
  output logic [WIDTH-1:0]           sr_in,
  input  logic [WIDTH-1:0]           sr_out,
  output logic                       seg_valid,
  output logic [$clog2(DEPTH)-1:0]   seg_idx,
  output logic [WIDTH-1:0]           seg_dir,
  output logic                       seg_tail,
  output logic                       frame_start,
  output logic [$clog2(DEPTH+1)-1:0] length,
  output logic                       full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);

  snake_state_t     state_q, state_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic             full_q, full_d;
  logic             seg_valid_q, seg_valid_d;
  logic [IDX_W-1:0] seg_idx_q, seg_idx_d;
  logic [WIDTH-1:0] seg_dir_q, seg_dir_d;
  logic             seg_tail_q, seg_tail_d;
  logic             frame_start_q, frame_start_d;

  logic [IDX_W-1:0] idx;
  logic             wrap;
  logic             load0;
  logic             load1;
  logic             accept;

  snake_ring_phase #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .load0 (load0),
    .load1 (load1),
    .idx   (idx),
    .wrap  (wrap)
  );

  // Control: state, length, ring input and the insertion handshake.
  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    load0      = 1'b0;
    load1      = 1'b0;
    sr_in      = INIT_DIR;
    move_ready = 1'b0;
    accept     = 1'b0;
    case (state_q)
      CLEAR: begin
        // The counter wraps to 0 by itself, so the first RUN cycle is idx 0.
        if (wrap) begin
          state_d  = RUN;
          length_d = LEN_W'(INIT_LEN);
        end
      end
      RUN: begin
        sr_in      = sr_out;
        // The slot holding the deepest entry is the only place a new head
        // can be written; restart masks it so restart always wins.
        move_ready = wrap && !restart;
        accept     = move_valid && move_ready;
        if (restart) begin
          state_d  = CLEAR;
          load0    = 1'b1;
          length_d = '0;
        end else if (accept) begin
          // New head replaces the discarded deepest entry; everything already
          // stored is now one segment deeper, hence the phase jumps to 1.
          sr_in = move_dir;
          load1 = 1'b1;
          if (move_grow && (length_q != LEN_W'(DEPTH))) begin
            length_d = length_q + LEN_W'(1);
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Segment stream, registered from the ring output.
  always_comb begin
    seg_valid_d   = (state_q == RUN) && (LEN_W'(idx) < length_q);
    seg_idx_d     = idx;
    seg_dir_d     = sr_out;
    seg_tail_d    = seg_valid_d && (LEN_W'(idx) == (length_q - LEN_W'(1)));
    frame_start_d = (state_q == RUN) && (idx == '0);
    full_d        = (length_d == LEN_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR;
      length_q      <= '0;
      full_q        <= 1'b0;
      seg_valid_q   <= 1'b0;
      seg_idx_q     <= '0;
      seg_dir_q     <= '0;
      seg_tail_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      length_q      <= length_d;
      full_q        <= full_d;
      seg_valid_q   <= seg_valid_d;
      seg_idx_q     <= seg_idx_d;
      seg_dir_q     <= seg_dir_d;
      seg_tail_q    <= seg_tail_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_valid   = seg_valid_q;
  assign seg_idx     = seg_idx_q;
  assign seg_dir     = seg_dir_q;
  assign seg_tail    = seg_tail_q;
  assign frame_start = frame_start_q;
  assign length      = length_q;
  assign full        = full_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_body_ctrl
// Bench for snake_body_ctrl with a behavioural DEPTH-stage shift ring attached.
// A small body model (head-first queue of directions plus a length) produces
// the expected segment records, which are queued and popped frame by frame.
// -----------------------------------------------------------------------------
module tb_snake_body_ctrl;
  import snake_pkg::*;

  localparam int         DEPTH    = 234;
  localparam int         WIDTH    = 2;
  localparam int         INIT_LEN = 3;
  localparam logic [1:0] INIT_DIR = DIR_RIGHT;
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam int         LEN_W    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             restart;
  logic             move_valid;
  logic [WIDTH-1:0] move_dir;
  logic             move_grow;
  logic             move_ready;
  logic [WIDTH-1:0] sr_in;
  logic [WIDTH-1:0] sr_out;
  logic             seg_valid;
  logic [IDX_W-1:0] seg_idx;
  logic [WIDTH-1:0] seg_dir;
  logic             seg_tail;
  logic             frame_start;
  logic [LEN_W-1:0] length;
  logic             full;

  // Free-running ring, no reset; starts full of a non-INIT value.
  logic [WIDTH-1:0] ring [DEPTH] = '{default: 2'd3};
  assign sr_out = ring[DEPTH-1];
  always @(posedge clk) begin
    ring[0] <= sr_in;
    for (int i = 1; i < DEPTH; i++) ring[i] <= ring[i-1];
  end

  snake_body_ctrl #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .INIT_LEN (INIT_LEN),
    .INIT_DIR (INIT_DIR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .restart     (restart),
    .move_valid  (move_valid),
    .move_dir    (move_dir),
    .move_grow   (move_grow),
    .move_ready  (move_ready),
    .sr_in       (sr_in),
    .sr_out      (sr_out),
    .seg_valid   (seg_valid),
    .seg_idx     (seg_idx),
    .seg_dir     (seg_dir),
    .seg_tail    (seg_tail),
    .frame_start (frame_start),
    .length      (length),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [1:0] dir;
    logic       vld;
    logic       tail;
  } seg_t;

  seg_t       sb[$];
  logic [1:0] body[$];
  int         exp_len;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    body.delete();
    for (int i = 0; i < DEPTH; i++) body.push_back(INIT_DIR);
    exp_len = INIT_LEN;
  endtask

  // Called on the negedge right after the clear began; counts to frame_start.
  task automatic measure_init(input string tag);
    int bad   = 0;
    int first = -1;
    for (int k = 0; k <= 240; k++) begin
      if (k > 0) @(negedge clk);
      if (frame_start) begin
        first = k;
        break;
      end
      if (move_ready) bad++;
    end
    chk({tag, " ready_in_clear"}, bad, 0);
    chk({tag, " first_frame_delay"}, first, 235);
  endtask

  task automatic push_frame(input int n);
    seg_t e;
    for (int i = 0; i < n; i++) begin
      e.idx  = i;
      e.dir  = body[i];
      e.vld  = (i < exp_len);
      e.tail = (i == exp_len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic check_frame(input string tag);
    int   w = 0;
    bit   first = 1'b1;
    seg_t e;
    while (!frame_start && w < 2 * DEPTH + 4) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " frame_found"}, frame_start, 1);
    while (sb.size() > 0) begin
      if (!first) @(negedge clk);
      first = 1'b0;
      e = sb.pop_front();
      chk($sformatf("%s seg_idx@%0d", tag, e.idx), seg_idx, e.idx);
      chk($sformatf("%s seg_dir@%0d", tag, e.idx), seg_dir, e.dir);
      chk($sformatf("%s seg_valid@%0d", tag, e.idx), seg_valid, e.vld);
      chk($sformatf("%s seg_tail@%0d", tag, e.idx), seg_tail, e.tail);
    end
    chk({tag, " length"}, length, exp_len);
    chk({tag, " full"}, full, (exp_len == DEPTH));
  endtask

  task automatic do_move(input string tag, input logic [1:0] dir, input logic grow);
    int w = 0;
    move_valid = 1'b1;
    move_dir   = dir;
    move_grow  = grow;
    while (!move_ready && w < DEPTH + 2) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready_within_depth"}, (w <= DEPTH), 1);
    @(negedge clk);
    move_valid = 1'b0;
    move_grow  = 1'b0;
    body.push_front(dir);
    void'(body.pop_back());
    if (grow && exp_len < DEPTH) exp_len++;
    chk({tag, " length_after_move"}, length, exp_len);
    chk({tag, " full_after_move"}, full, (exp_len == DEPTH));
  endtask

  initial begin
    int w;
    rst        = 1'b1;
    restart    = 1'b0;
    move_valid = 1'b0;
    move_dir   = '0;
    move_grow  = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst seg_valid", seg_valid, 0);
    chk("rst seg_idx", seg_idx, 0);
    chk("rst seg_dir", seg_dir, 0);
    chk("rst seg_tail", seg_tail, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst length", length, 0);
    chk("rst full", full, 0);
    chk("rst move_ready", move_ready, 0);
    chk("rst sr_in", sr_in, INIT_DIR);

    // Initial clear and first frame
    rst = 1'b0;
    measure_init("init");
    model_clear();
    push_frame(5);
    check_frame("init");

    // Single move without growth
    do_move("mv1", DIR_DOWN, 1'b0);
    push_frame(5);
    check_frame("mv1");

    // Restart colliding with a pending move in the insertion slot
    move_valid = 1'b1;
    move_dir   = DIR_LEFT;
    move_grow  = 1'b1;
    w = 0;
    while (!move_ready && w < DEPTH + 2) begin
      @(negedge clk);
      w++;
    end
    chk("rs slot_found", move_ready, 1);
    restart = 1'b1;
    #1;
    chk("rs ready_masked", move_ready, 0);
    @(negedge clk);
    restart    = 1'b0;
    move_valid = 1'b0;
    move_grow  = 1'b0;
    chk("rs length", length, 0);
    chk("rs seg_valid", seg_valid, 0);
    measure_init("rs");
    model_clear();
    push_frame(DEPTH);
    check_frame("rs");

    // Three growing moves
    do_move("g1", DIR_DOWN, 1'b1);
    do_move("g2", DIR_LEFT, 1'b1);
    do_move("g3", DIR_UP, 1'b1);
    push_frame(8);
    check_frame("g3");

    // Grow until full, then one more grow
    while (exp_len < DEPTH) begin
      do_move("grow", 2'($urandom_range(0, 3)), 1'b1);
    end
    do_move("overgrow", DIR_LEFT, 1'b1);
    push_frame(DEPTH);
    check_frame("full");

    // rst mid-frame in RUN
    w = 0;
    while (!frame_start && w < 2 * DEPTH + 4) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst seg_valid", seg_valid, 0);
    chk("midrst seg_idx", seg_idx, 0);
    chk("midrst length", length, 0);
    chk("midrst full", full, 0);
    chk("midrst frame_start", frame_start, 0);
    rst = 1'b0;
    measure_init("midrst");
    model_clear();
    push_frame(8);
    check_frame("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
